// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants and pipeline tag for the RAM port-A arbiter
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic REQ_LOADER  = 1'b0;
  localparam logic REQ_SCANNER = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
    logic is_read;
  } pipe_tag_t;

  localparam pipe_tag_t TAG_IDLE = '{valid: 1'b0, id: 1'b0, is_read: 1'b0};
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-granted pointer
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1,
  output logic grant_any,
  output logic grant_id
);

  logic last_q, last_d;

  // Every grant is an accept, so the pointer moves whenever anyone is valid.
  always_comb begin
    grant_id = REQ_LOADER;
    if (valid0 && valid1) begin
      grant_id = ~last_q;
    end else if (valid1) begin
      grant_id = REQ_SCANNER;
    end
    grant_any = valid0 | valid1;
    grant0    = grant_any && (grant_id == REQ_LOADER);
    grant1    = grant_any && (grant_id == REQ_SCANNER);
    last_d    = grant_any ? grant_id : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_SCANNER;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares RAM port A between loader and scanner with registered drives
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic grant0, grant1, grant_any, grant_id;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant_any(grant_any),
    .grant_id (grant_id)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  pipe_tag_t         s1_q, s1_d, s2_q, s2_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;

  always_comb begin
    win_we    = req0_we;
    win_addr  = req0_addr;
    win_wdata = req0_wdata;
    if (grant_id == REQ_SCANNER) begin
      win_we    = req1_we;
      win_addr  = req1_addr;
      win_wdata = req1_wdata;
    end
  end

  always_comb begin
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    s1_d         = TAG_IDLE;
    s2_d         = s1_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;

    if (grant_any) begin
      ram_we_d    = win_we;
      ram_addr_d  = win_addr;
      ram_wdata_d = win_wdata;
      s1_d        = '{valid: 1'b1, id: grant_id, is_read: !win_we};
    end

    // ram_rdata belongs to the access tagged in s2; only reads consume it.
    if (s2_q.valid && s2_q.is_read) begin
      if (s2_q.id == REQ_LOADER) begin
        rsp0_valid_d = 1'b1;
        rsp0_rdata_d = ram_rdata;
      end else begin
        rsp1_valid_d = 1'b1;
        rsp1_rdata_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      s1_q         <= TAG_IDLE;
      s2_q         <= TAG_IDLE;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule
